// File: rtl/multi_edge_debounce.sv
// Multi-channel button debouncer: two-flop synchronizer, per-channel stability counter,
// registered rise/fall/edge pulses and optional long-press (hold) detection.
module multi_edge_debounce #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned HOLD_CYC     = 0,
  parameter int unsigned EDGE_MODE    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] signal_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] edge_out,
  output logic [N_CH-1:0] hold_out,
  output logic            any_edge
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DebLast = DW'(DEBOUNCE_CYC - 1);

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] stable_q, stable_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic [DW-1:0]   deb_cnt_q [N_CH];
  logic [DW-1:0]   deb_cnt_d [N_CH];

  // Any cycle where the synchronized input agrees with the accepted level wipes the count.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      deb_cnt_d[i] = '0;
      stable_d[i]  = stable_q[i];
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= signal_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign level_out = stable_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;

  always_comb begin
    edge_out = '0;
    case (EDGE_MODE)
      0:       edge_out = rise_q;
      1:       edge_out = fall_q;
      default: edge_out = rise_q | fall_q;
    endcase
  end

  assign any_edge = |edge_out;

  if (HOLD_CYC > 0) begin : g_hold
    localparam int unsigned HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HoldMax  = HW'(HOLD_CYC);
    localparam logic [HW-1:0] HoldFire = HW'(HOLD_CYC - 1);

    logic [HW-1:0]   hold_cnt_q [N_CH];
    logic [HW-1:0]   hold_cnt_d [N_CH];
    logic [N_CH-1:0] hold_q, hold_d;

    // Counter climbs from 0 (rise cycle) and parks at HOLD_CYC, so the fire value is hit once.
    always_comb begin
      for (int i = 0; i < int'(N_CH); i++) begin
        hold_cnt_d[i] = '0;
        if (stable_d[i] && !rise_d[i]) begin
          hold_cnt_d[i] = (hold_cnt_q[i] < HoldMax) ? hold_cnt_q[i] + 1'b1 : hold_cnt_q[i];
        end
        hold_d[i] = stable_d[i] && (hold_cnt_d[i] == HoldFire);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
        for (int i = 0; i < int'(N_CH); i++) begin
          hold_cnt_q[i] <= '0;
        end
      end else begin
        hold_q <= hold_d;
        for (int i = 0; i < int'(N_CH); i++) begin
          hold_cnt_q[i] <= hold_cnt_d[i];
        end
      end
    end

    assign hold_out = hold_q;
  end else begin : g_no_hold
    assign hold_out = '0;
  end

endmodule

// File: tb/tb_multi_edge_debounce.sv
// Scoreboard bench for multi_edge_debounce: directed scenarios followed by random button traffic.
module tb_multi_edge_debounce;

  localparam int unsigned NCh  = 4;
  localparam int unsigned Deb  = 4;
  localparam int unsigned Hold = 10;

  logic           clk;
  logic           rst;
  logic [NCh-1:0] signal_in;
  logic [NCh-1:0] level_out, rise_out, fall_out, edge_out, hold_out;
  logic           any_edge;

  multi_edge_debounce #(
    .N_CH        (NCh),
    .DEBOUNCE_CYC(Deb),
    .HOLD_CYC    (Hold),
    .EDGE_MODE   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .signal_in(signal_in),
    .level_out(level_out),
    .rise_out (rise_out),
    .fall_out (fall_out),
    .edge_out (edge_out),
    .hold_out (hold_out),
    .any_edge (any_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCh-1:0] lvl;
    logic [NCh-1:0] rise;
    logic [NCh-1:0] fall;
    logic [NCh-1:0] edg;
    logic [NCh-1:0] hold;
    logic           any;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: inputs seen at past edges, how long the synchronized input has
  // disagreed with the accepted level, and how long each channel has been accepted high.
  logic [NCh-1:0] past1, past2;
  logic [NCh-1:0] m_lvl;
  int             m_run [NCh];
  int             m_age [NCh];

  task automatic model_step(input logic r, input logic [NCh-1:0] v);
    exp_t e;
    e = '0;
    if (r) begin
      past1 = '0;
      past2 = '0;
      m_lvl = '0;
      for (int c = 0; c < int'(NCh); c++) begin
        m_run[c] = 0;
        m_age[c] = 0;
      end
    end else begin
      for (int c = 0; c < int'(NCh); c++) begin
        // Input applied two edges ago is what the debouncer compares this edge.
        if (past2[c] != m_lvl[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == int'(Deb)) begin
          m_run[c] = 0;
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) e.rise[c] = 1'b1;
          else e.fall[c] = 1'b1;
        end
        if (e.rise[c]) m_age[c] = 0;
        else if (m_lvl[c] && m_age[c] < 1000000) m_age[c]++;
        else if (!m_lvl[c]) m_age[c] = 0;
        e.hold[c] = m_lvl[c] && (m_age[c] == int'(Hold) - 1);
      end
      past2 = past1;
      past1 = v;
    end
    e.lvl = m_lvl;
    e.edg = e.rise | e.fall;
    e.any = |e.edg;
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [NCh-1:0] v, input logic r, input int n);
    for (int k = 0; k < n; k++) begin
      rst       = r;
      signal_in = v;
      @(posedge clk);
      model_step(r, v);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [NCh-1:0] got, input logic [NCh-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL cyc=%0d %s got=%b expected=%b", cyc, name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("level_out", level_out, e.lvl);
      chk("rise_out", rise_out, e.rise);
      chk("fall_out", fall_out, e.fall);
      chk("edge_out", edge_out, e.edg);
      chk("hold_out", hold_out, e.hold);
      chk("any_edge", {3'b000, any_edge}, {3'b000, e.any});
    end
  end

  initial begin
    logic [NCh-1:0] rv;
    int             rem [NCh];
    past1     = '0;
    past2     = '0;
    m_lvl     = '0;
    rst       = 1'b1;
    signal_in = '0;
    for (int c = 0; c < int'(NCh); c++) begin
      m_run[c] = 0;
      m_age[c] = 0;
    end

    apply(4'b0000, 1'b1, 3);
    apply(4'b0000, 1'b0, 5);
    // ch0 press and hold
    apply(4'b0001, 1'b0, 12);
    // ch1 glitches of 1, 2, 3 cycles
    apply(4'b0011, 1'b0, 1);
    apply(4'b0001, 1'b0, 5);
    apply(4'b0011, 1'b0, 2);
    apply(4'b0001, 1'b0, 5);
    apply(4'b0011, 1'b0, 3);
    apply(4'b0001, 1'b0, 8);
    // ch2 press/release
    apply(4'b0101, 1'b0, 10);
    apply(4'b0001, 1'b0, 10);
    // ch3 long press, then short press
    apply(4'b1001, 1'b0, 30);
    apply(4'b0001, 1'b0, 10);
    apply(4'b1001, 1'b0, 6);
    apply(4'b0001, 1'b0, 10);
    apply(4'b0000, 1'b0, 10);
    // all channels together
    apply(4'b1111, 1'b0, 10);
    apply(4'b0000, 1'b0, 10);
    // reset in the middle of a count
    apply(4'b1111, 1'b0, 3);
    apply(4'b1111, 1'b1, 1);
    apply(4'b1111, 1'b0, 12);
    apply(4'b0000, 1'b0, 10);

    rv = '0;
    for (int c = 0; c < int'(NCh); c++) rem[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < int'(NCh); c++) begin
        if (rem[c] == 0) begin
          rv[c]  = ~rv[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 35))
                                               : int'($urandom_range(1, 7));
        end
        rem[c]--;
      end
      apply(rv, ($urandom_range(0, 399) == 0), 1);
    end
    apply(4'b0000, 1'b0, 3);

    repeat (4) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
